// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: character buffer plus HD44780 refresh sequencer.
//
// Writes land in a COLS x ROWS text buffer immediately, with no backpressure.
// Whenever the buffer is dirty and the sequencer is idle, a full refresh pass
// (address byte + COLS characters per row) is sent to the panel. Each pass
// works from a snapshot taken when it starts, so later writes never disturb a
// pass in flight; they only arm the next one.
//
// Build option: define LCD_SCROLL_EN to scroll the text up on row overflow;
// without it, row overflow blanks the whole buffer and homes the cursor.
//
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous, active-high
//   wr_valid  character write strobe (accepted every cycle)
//   wr_char   character code, 0x20..0x7E printable, 0x0D newline
//   clear     blank buffer and home cursor (wins over wr_valid)
//   busy      high whenever the sequencer is not idle
//   lcd_data  panel data bus
//   lcd_rs    register select (0 command, 1 character)
//   lcd_en    enable strobe
//   lcd_rw    tied low (write only)
//   lcd_on    tied high
//   lcd_blon  tied high
module lcd_text_ctrl #(
  parameter int COLS          = 16,
  parameter int ROWS          = 2,
  parameter int EN_CYCLES     = 16,
  parameter int SETTLE_CYCLES = 262143
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  input  logic       clear,
  output logic       busy,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic       lcd_rw,
  output logic       lcd_on,
  output logic       lcd_blon
);

  localparam int NB      = ROWS * COLS * 8;
  localparam int RB      = COLS * 8;
  localparam int CNT_MAX = (EN_CYCLES > SETTLE_CYCLES) ? EN_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [NB-1:0] BLANK = {(ROWS * COLS){8'h20}};

  typedef enum logic [2:0] {INIT, IDLE, ADDR, CHAR, STROBE, SETTLE} state_t;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic [7:0] row_addr(input logic [1:0] row);
    case (row)
      2'd0:    return 8'h80;
      2'd1:    return 8'hC0;
      2'd2:    return 8'h94;
      default: return 8'hD4;
    endcase
  endfunction

  function automatic logic [7:0] snap_byte(input logic [NB-1:0] s, input int row, input int col);
    return s[(row * COLS + col) * 8 +: 8];
  endfunction

  logic [NB-1:0]    r_buf;
  logic [NB-1:0]    r_snap;
  logic [1:0]       r_row;
  logic [4:0]       r_col;
  logic             r_dirty;
  state_t           r_state;
  state_t           r_from;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_init_idx;
  logic [1:0]       r_tx_row;
  logic [4:0]       r_tx_col;
  logic [7:0]       r_data;
  logic             r_rs;
  logic             r_en;
  logic             r_busy;

  logic [NB-1:0]    w_buf;
  logic [1:0]       w_row;
  logic [4:0]       w_col;
  logic             w_touch;
  logic             w_ovf;
  logic             w_start;

  assign w_start = (r_state == IDLE) && r_dirty;

  // Next buffer/cursor from this cycle's write or clear.
  always_comb begin
    w_buf   = r_buf;
    w_row   = r_row;
    w_col   = r_col;
    w_touch = 1'b0;
    w_ovf   = 1'b0;
    if (clear) begin
      w_buf   = BLANK;
      w_row   = 2'd0;
      w_col   = 5'd0;
      w_touch = 1'b1;
    end else if (wr_valid) begin
      if (wr_char >= 8'h20 && wr_char <= 8'h7E) begin
        w_buf[(int'(r_row) * COLS + int'(r_col)) * 8 +: 8] = wr_char;
        w_touch = 1'b1;
        if (r_col == 5'(COLS - 1)) begin
          w_col = 5'd0;
          if (r_row == 2'(ROWS - 1)) w_ovf = 1'b1;
          else                       w_row = r_row + 2'd1;
        end else begin
          w_col = r_col + 5'd1;
        end
      end else if (wr_char == 8'h0D) begin
        w_touch = 1'b1;
        w_col   = 5'd0;
        if (r_row == 2'(ROWS - 1)) w_ovf = 1'b1;
        else                       w_row = r_row + 2'd1;
      end
    end
    // Overflow is applied after the store so a wrapping character is kept
    // when scrolling.
    if (w_ovf) begin
`ifdef LCD_SCROLL_EN
      w_buf = w_buf >> RB;
      w_buf[NB-1 -: RB] = BLANK[RB-1:0];
      w_row = 2'(ROWS - 1);
      w_col = 5'd0;
`else
      w_buf = BLANK;
      w_row = 2'd0;
      w_col = 5'd0;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_buf <= BLANK;
      r_row <= 2'd0;
      r_col <= 5'd0;
    end else begin
      r_buf <= w_buf;
      r_row <= w_row;
      r_col <= w_col;
    end
  end

  // Snapshot taken on the same edge a pass starts.
  always_ff @(posedge clock) begin
    if (w_start) r_snap <= r_buf;
  end

  // Sequencer. ADDR/CHAR/INIT (with a loaded command) are the byte's cycle 0:
  // data/rs already presented, enable still low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= INIT;
      r_from     <= INIT;
      r_cnt      <= '0;
      r_init_idx <= 3'd0;
      r_tx_row   <= 2'd0;
      r_tx_col   <= 5'd0;
      r_data     <= 8'h00;
      r_rs       <= 1'b0;
      r_en       <= 1'b0;
      r_busy     <= 1'b1;
      r_dirty    <= 1'b1;
    end else begin
      case (r_state)
        INIT: begin
          if (r_init_idx == 3'd0) begin
            r_data     <= init_cmd(3'd0);
            r_rs       <= 1'b0;
            r_init_idx <= 3'd1;
          end else begin
            r_en    <= 1'b1;
            r_cnt   <= CNT_W'(1);
            r_from  <= INIT;
            r_state <= STROBE;
          end
        end
        IDLE: begin
          if (r_dirty) begin
            r_dirty  <= 1'b0;
            r_tx_row <= 2'd0;
            r_tx_col <= 5'd0;
            r_data   <= row_addr(2'd0);
            r_rs     <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= ADDR;
          end
        end
        ADDR, CHAR: begin
          r_en    <= 1'b1;
          r_cnt   <= CNT_W'(1);
          r_from  <= r_state;
          r_state <= STROBE;
        end
        STROBE: begin
          if (r_cnt == CNT_W'(EN_CYCLES)) begin
            r_en    <= 1'b0;
            r_cnt   <= CNT_W'(1);
            r_state <= SETTLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (r_cnt != CNT_W'(SETTLE_CYCLES)) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            case (r_from)
              INIT: begin
                if (r_init_idx == 3'd4) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
                end else begin
                  r_data     <= init_cmd(r_init_idx);
                  r_init_idx <= r_init_idx + 3'd1;
                  r_state    <= INIT;
                end
              end
              ADDR: begin
                r_data   <= snap_byte(r_snap, int'(r_tx_row), 0);
                r_rs     <= 1'b1;
                r_tx_col <= 5'd0;
                r_state  <= CHAR;
              end
              CHAR: begin
                if (r_tx_col != 5'(COLS - 1)) begin
                  r_data   <= snap_byte(r_snap, int'(r_tx_row), int'(r_tx_col) + 1);
                  r_tx_col <= r_tx_col + 5'd1;
                  r_state  <= CHAR;
                end else if (r_tx_row != 2'(ROWS - 1)) begin
                  r_data   <= row_addr(r_tx_row + 2'd1);
                  r_rs     <= 1'b0;
                  r_tx_row <= r_tx_row + 2'd1;
                  r_state  <= ADDR;
                end else begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
                end
              end
              default: begin
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            endcase
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
      // A write on the pass-start edge is not in the snapshot, so it re-arms.
      if (w_touch) r_dirty <= 1'b1;
    end
  end

  assign busy     = r_busy;
  assign lcd_data = r_data;
  assign lcd_rs   = r_rs;
  assign lcd_en   = r_en;
  assign lcd_rw   = 1'b0;
  assign lcd_on   = 1'b1;
  assign lcd_blon = 1'b1;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Testbench for lcd_text_ctrl (COLS=16, ROWS=2, EN_CYCLES=2, SETTLE_CYCLES=3).
// A negedge monitor records every enable pulse (bus value, high time, low gap
// before it, stability); the main sequence compares those records against
// byte streams built from a text-buffer reference model.
module tb_lcd_text_ctrl;
  localparam int COLS     = 16;
  localparam int ROWS     = 2;
  localparam int EN       = 2;
  localparam int ST       = 3;
  localparam int PASS_LEN = ROWS * (COLS + 1);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_char = 8'h00;
  logic       clear = 1'b0;
  logic       busy;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_en, lcd_rw, lcd_on, lcd_blon;

  lcd_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .EN_CYCLES(EN), .SETTLE_CYCLES(ST)) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_char(wr_char), .clear(clear),
    .busy(busy), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_en(lcd_en),
    .lcd_rw(lcd_rw), .lcd_on(lcd_on), .lcd_blon(lcd_blon)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Monitor records
  logic [8:0] q_bus[$];
  int         q_gap[$];
  int         q_hi[$];
  bit         q_stab[$];
  logic [8:0] exp_q[$];

  logic       m_prev_en;
  logic [8:0] m_prev_bus, m_rise_bus;
  int         m_hi, m_lo;
  bit         m_stab;

  always @(negedge clock) begin
    if (reset) begin
      m_prev_en = 1'b0; m_hi = 0; m_lo = 0; m_stab = 1'b1;
      m_prev_bus = {lcd_rs, lcd_data};
    end else begin
      if (lcd_en && !m_prev_en) begin
        m_rise_bus = {lcd_rs, lcd_data};
        m_stab = (m_prev_bus == m_rise_bus);
        q_bus.push_back(m_rise_bus);
        q_gap.push_back(m_lo);
        m_hi = 1;
      end else if (lcd_en) begin
        m_hi++;
        if ({lcd_rs, lcd_data} != m_rise_bus) m_stab = 1'b0;
      end else if (m_prev_en) begin
        q_hi.push_back(m_hi);
        q_stab.push_back(m_stab);
        m_lo = 1;
      end else begin
        m_lo++;
      end
      m_prev_en  = lcd_en;
      m_prev_bus = {lcd_rs, lcd_data};
    end
  end

  // Reference model: the text buffer and cursor
  logic [7:0] m_buf [ROWS][COLS];
  int m_row, m_col;

  function automatic void m_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_buf[r][c] = 8'h20;
    m_row = 0; m_col = 0;
  endfunction

  function automatic void m_next_row();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
`ifdef LCD_SCROLL_EN
      for (int r = 0; r < ROWS - 1; r++) m_buf[r] = m_buf[r + 1];
      for (int c = 0; c < COLS; c++) m_buf[ROWS - 1][c] = 8'h20;
      m_row = ROWS - 1;
`else
      m_reset();
`endif
    end
    m_col = 0;
  endfunction

  // Returns 1 when the character changes state (marks the buffer dirty).
  function automatic bit m_apply(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      m_buf[m_row][m_col] = ch;
      m_col++;
      if (m_col == COLS) m_next_row();
      return 1'b1;
    end else if (ch == 8'h0D) begin
      m_next_row();
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] row_off(input int r);
    case (r)
      0: return 8'h00;
      1: return 8'h40;
      2: return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  function automatic void exp_init();
    exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001); exp_q.push_back(9'h006);
  endfunction

  function automatic void exp_pass();
    for (int r = 0; r < ROWS; r++) begin
      exp_q.push_back({1'b0, 8'h80 | row_off(r)});
      for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, m_buf[r][c]});
    end
  endfunction

  // Pass from explicit row strings, independent of the model.
  function automatic void exp_rows(input string r0, input string r1);
    string rs [2];
    rs[0] = r0; rs[1] = r1;
    for (int r = 0; r < ROWS; r++) begin
      exp_q.push_back({1'b0, 8'h80 | row_off(r)});
      for (int c = 0; c < COLS; c++)
        exp_q.push_back({1'b1, (c < rs[r].len()) ? rs[r][c] : 8'h20});
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] ch);
    bit d;
    @(posedge clock); #1;
    wr_valid = 1'b1; wr_char = ch;
    @(posedge clock); #1;
    wr_valid = 1'b0;
    d = m_apply(ch);
  endtask

  task automatic wait_quiet();
    int quiet = 0;
    int n = 0;
    while (quiet < 40 && n < 6000) begin
      @(negedge clock);
      n++;
      if (busy === 1'b0) quiet++;
      else quiet = 0;
    end
    chk("idle_timeout", quiet >= 40, 1);
  endtask

  task automatic chk_timing();
    for (int i = 0; i < q_hi.size(); i++) begin
      chk("en_high_cycles", q_hi[i], EN);
      chk("data_stable", q_stab[i], 1);
    end
    for (int i = 1; i < q_bus.size(); i++) begin
      if (q_bus[i] == 9'h080) chk("gap_min", q_gap[i] >= ST + 1, 1);
      else chk("gap_settle", q_gap[i], ST + 1);
    end
  endtask

  task automatic flush();
    q_bus.delete(); q_gap.delete(); q_hi.delete(); q_stab.delete(); exp_q.delete();
  endtask

  // Exact byte stream comparison.
  task automatic check_run(input string tag);
    wait_quiet();
    chk_timing();
    chk({tag, "_nbytes"}, q_bus.size(), exp_q.size());
    for (int i = 0; i < q_bus.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, q_bus[i], exp_q[i]);
    flush();
  endtask

  // One or two passes allowed; the final pass must equal exp_q.
  task automatic check_last(input string tag);
    int n, base;
    wait_quiet();
    chk_timing();
    n = q_bus.size();
    chk({tag, "_passes"}, (n == PASS_LEN) || (n == 2 * PASS_LEN), 1);
    base = (n >= PASS_LEN) ? n - PASS_LEN : 0;
    for (int i = 0; i < PASS_LEN && base + i < n; i++)
      chk({tag, "_last"}, q_bus[base + i], exp_q[i]);
    flush();
  endtask

  initial begin
    string s;
    int n;
    bit d;
    logic [7:0] ch;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_en", lcd_en, 0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_busy", busy, 1);
    chk("rw", lcd_rw, 0);
    chk("on", lcd_on, 1);
    chk("blon", lcd_blon, 1);
    flush();
    m_reset();
    reset = 1'b0;

    // Power-up: init commands then a blank pass
    exp_init();
    exp_pass();
    check_run("init");
    chk("busy_after_init", busy, 0);

    // "HI" written while idle
    wr("H"); wr("I");
    exp_pass();
    check_last("hi");

    // Write during a pass: current pass unchanged, exactly one extra pass
    wr("x");
    n = 0;
    while (busy !== 1'b1 && n < 10) begin @(negedge clock); n++; end
    chk("pass_started", busy, 1);
    exp_pass();
    repeat (60) @(negedge clock);
    wr("A");
    exp_pass();
    check_run("during_pass");

    // Newline / row overflow behaviour
    @(posedge clock); #1; clear = 1'b1;
    @(posedge clock); #1; clear = 1'b0;
    m_reset();
    s = "AB"; for (int i = 0; i < s.len(); i++) wr(s[i]);
    wr(8'h0D);
    s = "CD"; for (int i = 0; i < s.len(); i++) wr(s[i]);
    wr(8'h0D);
    wr("E");
`ifdef LCD_SCROLL_EN
    exp_rows("CD", "E");
`else
    exp_rows("E", "");
`endif
    check_last("newline");

    // Clear beats a same-cycle write
    wr("Q"); wr("Q");
    @(posedge clock); #1; clear = 1'b1; wr_valid = 1'b1; wr_char = "Z";
    @(posedge clock); #1; clear = 1'b0; wr_valid = 1'b0;
    m_reset();
    exp_rows("", "");
    check_last("clear_z");
    wr("K");
    exp_rows("K", "");
    check_last("cursor_home");

    // Column wrap and row overflow via a long run of characters
    for (int i = 0; i < 2 * COLS + 3; i++) wr(8'h61 + 8'(i % 26));
    exp_pass();
    check_last("wrap");

    // Randomized single writes from idle
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, 9);
      if (n <= 5) ch = 8'($urandom_range(32, 126));
      else if (n == 6) ch = 8'h0D;
      else if (n == 7) ch = 8'($urandom_range(0, 12));
      else ch = 8'($urandom_range(127, 255));
      @(posedge clock); #1; wr_valid = 1'b1; wr_char = ch;
      @(posedge clock); #1; wr_valid = 1'b0;
      d = m_apply(ch);
      if (d) exp_pass();
      check_run("rand");
    end

    // Reset asserted while the enable is high
    wr("r");
    n = 0;
    while (lcd_en !== 1'b1 && n < 200) begin @(negedge clock); n++; end
    chk("en_seen", lcd_en, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_en", lcd_en, 0);
    chk("async_busy", busy, 1);
    chk("async_data", lcd_data, 8'h00);
    repeat (3) @(negedge clock);
    flush();
    m_reset();
    reset = 1'b0;
    exp_init();
    exp_pass();
    check_run("reinit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
